stage_wb: RTL
=============

# stage_wb

Writeback stage of the five-stage RV32 core, directly downstream of the memory stage. Registers the M→W pipeline payload and selects the final writeback value (load data or pre-computed result). Drives the register-file write port and the W-side hazard/forwarding request, and suppresses writeback for trapped instructions. Owns the retirement pulse and the 64-bit retired-instruction counter read by the CSR file.

## Interface
Parameters:
- INSTRET_RESET, 64'd0, value loaded into the instret counter on reset

Ports:
- clk  in  1  core clock; all state updates on posedge
- start  in  1  synchronous, active-low reset; state clears on a posedge while low
- control_signal_m  in  control_signal_t  M-stage control bundle (regwrite, resultsrc, memaccess used)
- instvalid_m  in  1  M slot holds a real instruction (0 = bubble/flushed)
- pc_m  in  32  M-stage PC
- rd_m  in  5  destination register
- result_m  in  32  pre-result (ALU / PC+4 / CSR) from memory stage
- memresult_m  in  32  extended load data from the LSU
- trap_req_m  in  trap_req_t  trap request leaving memory stage; valid squashes this instruction
- hazard_bus  interface  hazard_interface.requester  publishes rd_w and regwrite_w; consumes res.flush_w
- result_w  out  32  final writeback data (also forwarding source)
- rd_w  out  5  register-file write address
- regwrite_w  out  1  register-file write enable
- pc_w  out  32  PC of the instruction in W (trace/debug)
- retire_w  out  1  one-cycle pulse: W instruction retires this cycle
- instret  out  64  retired-instruction count
- instret_inhibit  in  1  mcountinhibit.IR; holds counter when 1
- instret_we_lo, instret_we_hi  in  1 each  CSR writes to minstret / minstreth
- instret_wdata  in  32  CSR write data

## Operation
- Pipeline register captures control_signal_m, instvalid_m, pc_m, rd_m, result_m, memresult_m; loads trap_req_m.valid as squash bit.
- start low or hazard_bus.res.flush_w high: register clears to zero (bubble); flush has priority over capture.
- No stall input: W always advances.
- result_w = memresult_w when resultsrc_w == RESULT_MEM, else result_w_reg.
- regwrite_w = regwrite_w_reg & valid_w & ~squash_w & (rd_w != 0).
- retire_w = valid_w & ~squash_w (instructions with no register write still retire).
- Counter update priority: instret_we_lo/hi > retire increment > hold.
  - we_lo: instret[31:0] ← wdata, upper unchanged; we_hi: instret[63:32] ← wdata, lower unchanged; both: both halves written.
  - Any CSR write in the same cycle as retire_w: write wins, that retire is not counted.
  - Otherwise retire_w & ~instret_inhibit: instret ← instret + 1, modulo 2^64 (all-ones wraps to 0).

## Timing
- M→W latency one cycle; result_w, rd_w, regwrite_w, retire_w combinational from W register.
- instret reflects retirements through the previous cycle; increment visible the cycle after retire_w.
- Reset values: result_w 0, rd_w 0, regwrite_w 0, pc_w 0, retire_w 0, instret INSTRET_RESET.
- Reset mid-operation: W contents discarded, no write/retire in the reset cycle or the first cycle after.

## Configuration
- STAGE_WB_INSTRET_EN defined: counter, CSR write path and inhibit implemented as above.
- Not defined: no counter flops; instret tied to 64'd0; instret_* inputs ignored; retire_w still generated.

## Structure
- riscv_defines package: add RESULT_MEM to the resultsrc enum (if absent) and flush_w to the hazard response struct; INSTRET width constant.
- One sub-module: retire_counter (64-bit counter, split-word CSR write, inhibit), instantiated under STAGE_WB_INSTRET_EN.

## Test plan
- Load rd=5, memresult_m=0xDEADBEEF, resultsrc MEM -> next cycle result_w=0xDEADBEEF, rd_w=5, regwrite_w=1, retire_w=1.
- ALU instruction to rd=0 -> regwrite_w=0, retire_w=1, instret +1.
- trap_req_m.valid=1 with regwrite -> regwrite_w=0, retire_w=0, instret unchanged.
- flush_w with valid instruction in M -> next cycle bubble: all W outputs 0.
- instret=0xFFFF_FFFF_FFFF_FFFF, retire -> 0; we_hi=1, wdata=0x12 with retire same cycle -> instret=0x0000_0012_xxxx (low unchanged, no increment).
- instret_inhibit=1 over 3 retires -> unchanged; assert start low mid-stream -> instret=INSTRET_RESET, outputs 0.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared RV32 pipeline types: writeback source select, M-stage control,
// trap request and hazard unit request/response bundles.
package riscv_defines;

   localparam int XLEN      = 32;
   localparam int INSTRET_W = 64;

   typedef enum logic [1:0] {
      RESULT_ALU = 2'd0,
      RESULT_MEM = 2'd1,
      RESULT_PC4 = 2'd2,
      RESULT_CSR = 2'd3
   } resultsrc_t;

   typedef struct packed {
      logic       regwrite;
      resultsrc_t resultsrc;
      logic       memaccess;
   } control_signal_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  cause;
      logic [31:0] tval;
   } trap_req_t;

   typedef struct packed {
      logic [4:0] rd_w;
      logic       regwrite_w;
   } hazard_req_t;

   typedef struct packed {
      logic flush_w;
   } hazard_res_t;

endpackage

// File: rtl/hazard_interface.sv
// Link between a pipeline stage (requester) and the hazard/forwarding unit.
interface hazard_interface;
   import riscv_defines::*;

   hazard_req_t req;
   hazard_res_t res;

   modport requester (output req, input res);
   modport responder (input req, output res);
endinterface

// File: rtl/retire_counter.sv
// 64-bit retired-instruction counter with split-word CSR writes and inhibit.
module retire_counter
   import riscv_defines::*;
#(
   parameter logic [INSTRET_W-1:0] INSTRET_RESET = 64'd0
) (
   input  logic                 clk,
   input  logic                 start,
   input  logic                 retire,
   input  logic                 inhibit,
   input  logic                 we_lo,
   input  logic                 we_hi,
   input  logic [31:0]          wdata,
   output logic [INSTRET_W-1:0] count
);

   // A CSR write in the same cycle as a retirement swallows that increment.
   always_ff @(posedge clk) begin
      if (!start) begin
         count <= INSTRET_RESET;
      end else if (we_lo || we_hi) begin
         if (we_lo) count[31:0]  <= wdata;
         if (we_hi) count[63:32] <= wdata;
      end else if (retire && !inhibit) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: M->W register, writeback mux, retire pulse, instret.
// Define STAGE_WB_INSTRET_EN to build the instret counter and CSR path.
module stage_wb
   import riscv_defines::*;
#(
   parameter logic [63:0] INSTRET_RESET = 64'd0
) (
   input  logic                      clk,
   input  logic                      start,
   input  control_signal_t           control_signal_m,
   input  logic                      instvalid_m,
   input  logic [31:0]               pc_m,
   input  logic [4:0]                rd_m,
   input  logic [31:0]               result_m,
   input  logic [31:0]               memresult_m,
   input  trap_req_t                 trap_req_m,
   hazard_interface.requester        hazard_bus,
   output logic [31:0]               result_w,
   output logic [4:0]                rd_w,
   output logic                      regwrite_w,
   output logic [31:0]               pc_w,
   output logic                      retire_w,
   output logic [63:0]               instret,
   input  logic                      instret_inhibit,
   input  logic                      instret_we_lo,
   input  logic                      instret_we_hi,
   input  logic [31:0]               instret_wdata
);

   logic        regwrite_q;
   resultsrc_t  resultsrc_q;
   logic        valid_q;
   logic        squash_q;
   logic [31:0] pc_q;
   logic [4:0]  rd_q;
   logic [31:0] result_q;
   logic [31:0] memresult_q;
   logic        live;
   logic        unused;

   always_ff @(posedge clk) begin
      if (!start || hazard_bus.res.flush_w) begin
         regwrite_q  <= 1'b0;
         resultsrc_q <= RESULT_ALU;
         valid_q     <= 1'b0;
         squash_q    <= 1'b0;
         pc_q        <= '0;
         rd_q        <= '0;
         result_q    <= '0;
         memresult_q <= '0;
      end else begin
         regwrite_q  <= control_signal_m.regwrite;
         resultsrc_q <= control_signal_m.resultsrc;
         valid_q     <= instvalid_m;
         squash_q    <= trap_req_m.valid;
         pc_q        <= pc_m;
         rd_q        <= rd_m;
         result_q    <= result_m;
         memresult_q <= memresult_m;
      end
   end

   // Held-low start kills any stale W contents in the reset cycle itself.
   assign live       = valid_q & ~squash_q & start;
   assign retire_w   = live;
   assign regwrite_w = live & regwrite_q & (rd_q != 5'd0);
   assign rd_w       = rd_q;
   assign pc_w       = pc_q;
   assign result_w   = (resultsrc_q == RESULT_MEM) ? memresult_q
                                                   : result_q;

   assign hazard_bus.req.rd_w       = rd_w;
   assign hazard_bus.req.regwrite_w = regwrite_w;

`ifdef STAGE_WB_INSTRET_EN
   retire_counter #(
      .INSTRET_RESET (INSTRET_RESET)
   ) u_retire_counter (
      .clk     (clk),
      .start   (start),
      .retire  (retire_w),
      .inhibit (instret_inhibit),
      .we_lo   (instret_we_lo),
      .we_hi   (instret_we_hi),
      .wdata   (instret_wdata),
      .count   (instret)
   );

   assign unused = ^{control_signal_m.memaccess,
                     trap_req_m.cause, trap_req_m.tval};
`else
   assign instret = 64'd0;

   assign unused = ^{control_signal_m.memaccess,
                     trap_req_m.cause, trap_req_m.tval,
                     instret_inhibit, instret_we_lo,
                     instret_we_hi, instret_wdata,
                     INSTRET_RESET};
`endif

endmodule
